// File: rtl/pusch_out_pkg.sv
// Shared constants and helpers for the PUSCH I/Q output formatter: default
// geometry, rounding shift, saturation limits and FIFO entry field layout.
package pusch_out_pkg;

  localparam int DEF_IN_WIDTH      = 26;
  localparam int DEF_OUT_WIDTH     = 16;
  localparam int DEF_FIFO_DEPTH    = 16;
  localparam int DEF_SYM_LEN       = 2192;
  localparam int DEF_SYMS_PER_SLOT = 14;

  // FIFO entry layout: {sos, eos, data}; tags sit directly above the data field.
  localparam int ENTRY_DATA_LSB = 0;

  function automatic int shift_of(input int in_w, input int out_w);
    return in_w - out_w;
  endfunction

  function automatic int sat_pos(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_neg(input int w);
    return -(1 << (w - 1));
  endfunction

  function automatic int entry_eos_bit(input int out_w);
    return ENTRY_DATA_LSB + 2 * out_w;
  endfunction

  function automatic int entry_sos_bit(input int out_w);
    return ENTRY_DATA_LSB + 2 * out_w + 1;
  endfunction

  function automatic int entry_width(input int out_w);
    return 2 * out_w + 2;
  endfunction

  // Counter width that stays legal for a modulus of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iq_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers and a
// synchronous clear; rd_data reads as zero while empty.
module iq_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty && !clear;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && !clear && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; the empty gate on the read port hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pusch_iq_out_formatter.sv
// Rounds/saturates IFFT I/Q to OUT_WIDTH, tags symbol/slot boundaries and
// buffers words for a valid/ready consumer. Optional saturation event counter
// is compiled in with PUSCH_IQ_SAT_CNT_EN.
module pusch_iq_out_formatter
  import pusch_out_pkg::*;
#(
  parameter int IN_WIDTH      = DEF_IN_WIDTH,
  parameter int OUT_WIDTH     = DEF_OUT_WIDTH,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int SYM_LEN       = DEF_SYM_LEN,
  parameter int SYMS_PER_SLOT = DEF_SYMS_PER_SLOT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [IN_WIDTH-1:0]    in_r,
  input  logic [IN_WIDTH-1:0]    in_i,
  output logic [2*OUT_WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sos,
  output logic                   out_eos,
  output logic                   overflow,
  output logic                   sat_flag,
  output logic [15:0]            sat_count
);

  localparam int SHIFT   = shift_of(IN_WIDTH, OUT_WIDTH);
  localparam int DW      = 2 * OUT_WIDTH;
  localparam int EW      = entry_width(OUT_WIDTH);
  localparam int EOS_BIT = entry_eos_bit(OUT_WIDTH);
  localparam int SOS_BIT = entry_sos_bit(OUT_WIDTH);
  localparam int SAMP_W  = cnt_width(SYM_LEN);
  localparam int SYM_W   = cnt_width(SYMS_PER_SLOT);

  localparam logic [OUT_WIDTH-1:0] POS_LIM = OUT_WIDTH'(sat_pos(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0] NEG_LIM = OUT_WIDTH'(sat_neg(OUT_WIDTH));
  localparam logic [IN_WIDTH:0]    HALF    = (IN_WIDTH+1)'(1) << (SHIFT - 1);

  // Returns {saturated, value}. The sum is one bit wider than the input so the
  // rounding constant never wraps; the shifted result keeps one guard bit.
  function automatic logic [OUT_WIDTH:0] round_sat(input logic [IN_WIDTH-1:0] x);
    logic signed [IN_WIDTH:0]  tmp;
    logic signed [OUT_WIDTH:0] y;
    tmp = $signed({x[IN_WIDTH-1], x}) + $signed(HALF);
    y   = (OUT_WIDTH+1)'(tmp >>> SHIFT);
    if (y[OUT_WIDTH] != y[OUT_WIDTH-1]) return {1'b1, (y[OUT_WIDTH] ? NEG_LIM : POS_LIM)};
    return {1'b0, y[OUT_WIDTH-1:0]};
  endfunction

  logic [SAMP_W-1:0]  samp_cnt;
  logic [SYM_W-1:0]   sym_cnt;
  logic               samp_last;
  logic               sym_last;
  logic [OUT_WIDTH:0] res_r;
  logic [OUT_WIDTH:0] res_i;

  logic               s1_valid;
  logic [DW-1:0]      s1_word;
  logic               s1_sos;
  logic               s1_eos;
  logic               s1_sat;

  logic [EW-1:0]      fifo_wr;
  logic [EW-1:0]      fifo_rd;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               drop;

  assign samp_last = (samp_cnt == SAMP_W'(SYM_LEN - 1));
  assign sym_last  = (sym_cnt == SYM_W'(SYMS_PER_SLOT - 1));
  assign res_r     = round_sat(in_r);
  assign res_i     = round_sat(in_i);

  // Framing counters advance on every accepted sample, dropped or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt <= '0;
      sym_cnt  <= '0;
    end else if (clear) begin
      samp_cnt <= '0;
      sym_cnt  <= '0;
    end else if (in_valid) begin
      if (samp_last) begin
        samp_cnt <= '0;
        sym_cnt  <= sym_last ? '0 : sym_cnt + SYM_W'(1);
      end else begin
        samp_cnt <= samp_cnt + SAMP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_sos   <= 1'b0;
      s1_eos   <= 1'b0;
      s1_sat   <= 1'b0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_sat   <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_word <= {res_r[OUT_WIDTH-1:0], res_i[OUT_WIDTH-1:0]};
        s1_sos  <= (samp_cnt == '0);
        s1_eos  <= samp_last && sym_last;
        s1_sat  <= res_r[OUT_WIDTH] | res_i[OUT_WIDTH];
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    fifo_wr                              = '0;
    fifo_wr[ENTRY_DATA_LSB +: DW]        = s1_word;
    fifo_wr[EOS_BIT]                     = s1_eos;
    fifo_wr[SOS_BIT]                     = s1_sos;
  end

  assign pop  = out_valid && out_ready;
  assign drop = s1_valid && fifo_full && !pop;

  iq_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .push    (s1_valid),
    .pop     (pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rd[ENTRY_DATA_LSB +: DW];
  assign out_eos   = fifo_rd[EOS_BIT];
  assign out_sos   = fifo_rd[SOS_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      sat_flag <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (drop)               overflow <= 1'b1;
      if (s1_valid && s1_sat) sat_flag <= 1'b1;
    end
  end

`ifdef PUSCH_IQ_SAT_CNT_EN
  // Saturates at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (clear) begin
      sat_count <= '0;
    end else if (s1_valid && s1_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_pusch_iq_out_formatter.sv
// Self-checking bench for pusch_iq_out_formatter: directed vector table,
// framing/back-pressure/reset/clear sequences and a randomized phase scored
// against a queue-based reference model.
module tb_pusch_iq_out_formatter;

  localparam int SLEN  = 4;
  localparam int NSYM  = 2;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [25:0] in_r = '0;
  logic [25:0] in_i = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_sos;
  logic        out_eos;
  logic        overflow;
  logic        sat_flag;
  logic [15:0] sat_count;

  always #5 clk = ~clk;

  pusch_iq_out_formatter #(
    .IN_WIDTH      (26),
    .OUT_WIDTH     (16),
    .FIFO_DEPTH    (DEPTH),
    .SYM_LEN       (SLEN),
    .SYMS_PER_SLOT (NSYM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sos   (out_sos),
    .out_eos   (out_eos),
    .overflow  (overflow),
    .sat_flag  (sat_flag),
    .sat_count (sat_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic        sos;
    logic        eos;
  } word_t;

  word_t q[$];
  logic  m_s1_valid;
  word_t m_s1;
  logic  m_s1_sat;
  int    k;
  logic  m_ovf;
  logic  m_sat;
  int    m_cnt;

  // {saturated, value}: floor((x + 512) / 1024) clamped to 16-bit signed.
  function automatic logic [16:0] ref_round(input logic [25:0] v);
    longint x, t, y;
    x = longint'($signed(v));
    t = x + 512;
    if (t >= 0) y = t / 1024;
    else        y = -((-t + 1023) / 1024);
    if (y > 32767)  return {1'b1, 16'h7FFF};
    if (y < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(y)};
  endfunction

  function automatic logic [31:0] ref_word(input logic [25:0] r, input logic [25:0] i);
    logic [16:0] a, b;
    a = ref_round(r);
    b = ref_round(i);
    return {a[15:0], b[15:0]};
  endfunction

  task automatic model_reset();
    q.delete();
    m_s1_valid = 1'b0;
    m_s1_sat   = 1'b0;
    k          = 0;
    m_ovf      = 1'b0;
    m_sat      = 1'b0;
    m_cnt      = 0;
  endtask

  // Advances the model by one clock using the inputs sampled at that edge.
  task automatic model_edge();
    bit          pop, full;
    logic [16:0] a, b;
    if (clear) begin
      model_reset();
      return;
    end
    pop  = (q.size() > 0) && out_ready;
    full = (q.size() == DEPTH);
    if (m_s1_valid && m_s1_sat) begin
      m_sat = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
    if (pop) void'(q.pop_front());
    if (m_s1_valid) begin
      if (!full || pop) q.push_back(m_s1);
      else              m_ovf = 1'b1;
    end
    m_s1_valid = in_valid;
    if (in_valid) begin
      a = ref_round(in_r);
      b = ref_round(in_i);
      m_s1.data = {a[15:0], b[15:0]};
      m_s1.sos  = (k % SLEN) == 0;
      m_s1.eos  = (k % (SLEN * NSYM)) == (SLEN * NSYM - 1);
      m_s1_sat  = a[16] | b[16];
      k++;
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_cnt;
`ifdef PUSCH_IQ_SAT_CNT_EN
    exp_cnt = 32'(m_cnt);
`else
    exp_cnt = 32'd0;
`endif
    check("m_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("m_data", out_data, q[0].data);
      check("m_sos", out_sos, q[0].sos);
      check("m_eos", out_eos, q[0].eos);
    end else begin
      check("m_data_idle", out_data, 32'd0);
      check("m_sos_idle", out_sos, 1'b0);
      check("m_eos_idle", out_eos, 1'b0);
    end
    check("m_overflow", overflow, m_ovf);
    check("m_sat_flag", sat_flag, m_sat);
    check("m_sat_count", sat_count, exp_cnt);
  endtask

  function automatic logic [25:0] rnd_sample();
    case ($urandom_range(0, 3))
      0:       return 26'h1FFFFFF - 26'($urandom_range(0, 600));
      1:       return 26'h2000000 + 26'($urandom_range(0, 600));
      default: return 26'($urandom);
    endcase
  endfunction

  task automatic step(input logic v, input logic [25:0] r, input logic [25:0] i,
                      input logic rdy, input logic clr);
    in_valid  = v;
    in_r      = r;
    in_i      = i;
    out_ready = rdy;
    clear     = clr;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_data"}, out_data, 32'd0);
    check({tag, "_sos"}, out_sos, 1'b0);
    check({tag, "_eos"}, out_eos, 1'b0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_sat_flag"}, sat_flag, 1'b0);
    check({tag, "_sat_count"}, sat_count, 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [25:0] r;
    logic [25:0] i;
    logic [31:0] word;
    logic        sat;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] exp_words[16];
  logic [25:0] r, i;
  int          w;

  initial begin
    vecs[0] = '{26'h0000200, 26'h0000000, 32'h0001_0000, 1'b0};
    vecs[1] = '{26'h00001FF, 26'h0000000, 32'h0000_0000, 1'b0};
    vecs[2] = '{26'h3FFFE00, 26'h0000000, 32'h0000_0000, 1'b0};
    vecs[3] = '{26'h3FFFDFF, 26'h0000000, 32'hFFFF_0000, 1'b0};
    vecs[4] = '{26'h0000000, 26'h0000200, 32'h0000_0001, 1'b0};
    vecs[5] = '{26'h0000000, 26'h3FFFDFF, 32'h0000_FFFF, 1'b0};
    vecs[6] = '{26'h1FFFFFF, 26'h2000000, 32'h7FFF_8000, 1'b1};

    model_reset();
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Rounding / saturation table.
    foreach (vecs[n]) begin
      step(1'b1, vecs[n].r, vecs[n].i, 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b0);
      check("tbl_valid", out_valid, 1'b1);
      check("tbl_word", out_data, vecs[n].word);
      check("tbl_sat_flag", sat_flag, vecs[n].sat);
      step(1'b0, '0, '0, 1'b1, 1'b0);
    end
`ifdef PUSCH_IQ_SAT_CNT_EN
    check("tbl_sat_count", sat_count, 32'd1);
`else
    check("tbl_sat_count", sat_count, 32'd0);
`endif

    // Framing, latency and throughput.
    step(1'b0, '0, '0, 1'b1, 1'b1);
    w = 0;
    for (int c = 0; c < 18; c++) begin
      step(c < 16, rnd_sample(), rnd_sample(), 1'b1, 1'b0);
      if (c == 0) check("latency_early", out_valid, 1'b0);
      if (c >= 1 && c <= 16) check("throughput", out_valid, 1'b1);
      if (c == 17) check("frame_drained", out_valid, 1'b0);
      if (out_valid) begin
        check("frame_sos", out_sos, (w % 4) == 0);
        check("frame_eos", out_eos, (w % 8) == 7);
        w++;
      end
    end
    check("frame_words", w, 16);

    // Back-pressure: 20 samples into a stalled consumer.
    step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int j = 0; j < 20; j++) begin
      r = rnd_sample();
      i = rnd_sample();
      if (j < 16) exp_words[j] = ref_word(r, i);
      step(1'b1, r, i, 1'b0, 1'b0);
      if (j >= 1) check("stall_hold", out_data, exp_words[0]);
      if (j == 16) check("ovf_before", overflow, 1'b0);
      if (j == 17) check("ovf_after", overflow, 1'b1);
    end
    for (int j = 0; j < 3; j++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0);
      check("stall_hold_idle", out_data, exp_words[0]);
    end
    for (int j = 0; j < 16; j++) begin
      check("drain_valid", out_valid, 1'b1);
      check("drain_data", out_data, exp_words[j]);
      step(1'b0, '0, '0, 1'b1, 1'b0);
    end
    check("drain_empty", out_valid, 1'b0);
    for (int j = 0; j < 10; j++) step(j < 8, rnd_sample(), rnd_sample(), 1'b1, 1'b0);

    // Full FIFO with a simultaneous pop every cycle.
    step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int j = 0; j < 17; j++) step(1'b1, rnd_sample(), rnd_sample(), 1'b0, 1'b0);
    for (int j = 0; j < 30; j++) begin
      step(1'b1, rnd_sample(), rnd_sample(), 1'b1, 1'b0);
      check("fullpop_ovf", overflow, 1'b0);
      check("fullpop_valid", out_valid, 1'b1);
    end
    for (int j = 0; j < 20; j++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Reset mid-slot with five words buffered.
    step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int j = 0; j < 5; j++) step(1'b1, 26'h1FFFFFF, rnd_sample(), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check("pre_reset_valid", out_valid, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, rnd_sample(), rnd_sample(), 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("post_reset_valid", out_valid, 1'b1);
    check("post_reset_sos", out_sos, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomized traffic with stalls and occasional clears.
    for (int j = 0; j < 400; j++) begin
      step($urandom_range(0, 3) != 0, rnd_sample(), rnd_sample(),
           $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
    end

    // Clear mid-slot with overflow and saturation pending; the sample on clear is discarded.
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 26'h1FFFFFF, 26'h0, 1'b0, 1'b0);
    for (int j = 0; j < 18; j++) step(1'b1, rnd_sample(), rnd_sample(), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check("pre_clear_ovf", overflow, 1'b1);
    check("pre_clear_sat", sat_flag, 1'b1);
    step(1'b1, rnd_sample(), rnd_sample(), 1'b1, 1'b1);
    check_all_zero("clear");
    step(1'b1, rnd_sample(), rnd_sample(), 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("post_clear_valid", out_valid, 1'b1);
    check("post_clear_sos", out_sos, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("post_clear_empty", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
